// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [3:0]  OP_MAX   = 4'd7;
    localparam logic [3:0]  SEL_PARK = 4'hF;
    localparam int unsigned STAT_W   = 16;
    localparam int unsigned CNT_W    = 4;

endpackage : alu_seq_pkg

// File: rtl/alu_op_sequencer.sv
// Issues one ALU op at a time through the result mux and returns the captured result.
// Optional response statistics counters are enabled with `define ALU_SEQ_STATS_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned SIZE       = 3,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [SIZE-1:0]   req_a,
    input  logic [SIZE-1:0]   req_b,
    output logic [SIZE-1:0]   op_a,
    output logic [SIZE-1:0]   op_b,
    output logic [3:0]        mux_sel,
    input  logic [SIZE+1:0]   mux_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [SIZE+1:0]   rsp_data,
    output logic              rsp_err
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_ops,
    output logic [STAT_W-1:0] stat_errs
`endif
);

    localparam int unsigned RES_W = SIZE + 2;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0]    op_a_q, op_a_d;
    logic [SIZE-1:0]    op_b_q, op_b_d;
    logic [3:0]         mux_sel_q, mux_sel_d;
    logic [RES_W-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;

    // Next-state, operand capture and result capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        mux_sel_d  = mux_sel_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_a_d = req_a;
                    op_b_d = req_b;
                    if (req_op <= OP_MAX) begin
                        cnt_d     = CNT_W'(SETTLE_CYC - 1);
                        mux_sel_d = req_op;
                        state_d   = SETTLE;
                    end else begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    rsp_data_d = mux_out;
                    rsp_err_d  = 1'b0;
                    mux_sel_d  = SEL_PARK;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                mux_sel_d = SEL_PARK;
                state_d   = IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next-state decode.
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            mux_sel_q   <= SEL_PARK;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            mux_sel_q   <= mux_sel_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign mux_sel   = mux_sel_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

`ifdef ALU_SEQ_STATS_EN
    logic [STAT_W-1:0] stat_ops_q, stat_ops_d;
    logic [STAT_W-1:0] stat_errs_q, stat_errs_d;

    // Count completed responses by outcome; both counters wrap naturally.
    always_comb begin
        stat_ops_d  = stat_ops_q;
        stat_errs_d = stat_errs_q;
        if (rsp_valid_q && rsp_ready) begin
            if (rsp_err_q) begin
                stat_errs_d = stat_errs_q + STAT_W'(1);
            end else begin
                stat_ops_d = stat_ops_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q  <= '0;
            stat_errs_q <= '0;
        end else begin
            stat_ops_q  <= stat_ops_d;
            stat_errs_q <= stat_errs_d;
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_errs = stat_errs_q;
`endif

endmodule : alu_op_sequencer
